// File: rtl/conv_rr_arbiter.sv
// Round-robin front-end that time-shares one conv engine between N requester streams.
// A job is X samples loaded followed by X-F+1 outputs drained; handshakes are forwarded, never buffered.
module conv_rr_arbiter #(
    parameter int N = 2,
    parameter int X = 32,
    parameter int F = 6,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*W-1:0]   req_x_data,
    input  logic [N-1:0]     req_x_valid,
    output logic [N-1:0]     req_x_ready,
    output logic [W-1:0]     req_y_data,
    output logic [N-1:0]     req_y_valid,
    input  logic [N-1:0]     req_y_ready,
    output logic [W-1:0]     eng_x_data,
    output logic             eng_x_valid,
    input  logic             eng_x_ready,
    input  logic [W-1:0]     eng_y_data,
    input  logic             eng_y_valid,
    output logic             eng_y_ready,
    output logic [N-1:0]     grant,
    output logic             busy
);

    localparam int CW = $clog2(X + 1);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] X_LAST = CW'(X - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(X - F);
    localparam logic [GW:0]   N_W    = (GW + 1)'(N);
    localparam logic [GW-1:0] G_MAX  = GW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_gidx;
    logic [CW-1:0]   r_x_cnt;
    logic [CW-1:0]   r_y_cnt;
    logic [N-1:0]    r_grant;
    logic            r_busy;

    logic            w_found;
    logic [GW-1:0]   w_win;
    logic [N-1:0]    w_win_onehot;
    logic            w_x_hs;
    logic            w_y_hs;

    // Scan requests starting at the pointer, wrapping modulo N; first hit wins.
    always_comb begin
        logic [GW:0] idx;
        w_found      = 1'b0;
        w_win        = '0;
        idx          = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, r_rr_ptr} + (GW + 1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!w_found && req_x_valid[idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_win   = idx[GW-1:0];
            end
        end
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    assign w_x_hs = (r_state == LOAD)  && req_x_valid[r_gidx] && eng_x_ready;
    assign w_y_hs = (r_state == DRAIN) && eng_y_valid && req_y_ready[r_gidx];

    always_comb begin
        req_x_ready = '0;
        req_y_valid = '0;
        req_y_data  = '0;
        eng_x_data  = '0;
        eng_x_valid = 1'b0;
        eng_y_ready = 1'b0;
        case (r_state)
            LOAD: begin
                eng_x_data          = req_x_data[r_gidx*W +: W];
                eng_x_valid         = req_x_valid[r_gidx];
                req_x_ready[r_gidx] = eng_x_ready;
            end
            DRAIN: begin
                req_y_data          = eng_y_data;
                req_y_valid[r_gidx] = eng_y_valid;
                eng_y_ready         = req_y_ready[r_gidx];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gidx   <= '0;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= LOAD;
                        r_gidx  <= w_win;
                        r_x_cnt <= '0;
                        r_y_cnt <= '0;
                        r_grant <= w_win_onehot;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_x_hs) begin
                        r_x_cnt <= r_x_cnt + 1'b1;
                        if (r_x_cnt == X_LAST) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_y_hs) begin
                        r_y_cnt <= r_y_cnt + 1'b1;
                        if (r_y_cnt == Y_LAST) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= (r_gidx == G_MAX) ? '0 : r_gidx + 1'b1;
                            r_grant  <= '0;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: tb/tb_conv_rr_arbiter.sv
// Self-checking bench: plays two requesters and a behavioural conv engine around the arbiter,
// with a scoreboard of expected outputs filled as each requester finishes sending a job.
module tb_conv_rr_arbiter;

    localparam int N  = 2;
    localparam int X  = 32;
    localparam int F  = 6;
    localparam int W  = 16;
    localparam int YN = X - F + 1;

    logic             clk;
    logic             reset;
    logic [N*W-1:0]   req_x_data;
    logic [N-1:0]     req_x_valid;
    logic [N-1:0]     req_x_ready;
    logic [W-1:0]     req_y_data;
    logic [N-1:0]     req_y_valid;
    logic [N-1:0]     req_y_ready;
    logic [W-1:0]     eng_x_data;
    logic             eng_x_valid;
    logic             eng_x_ready;
    logic [W-1:0]     eng_y_data;
    logic             eng_y_valid;
    logic             eng_y_ready;
    logic [N-1:0]     grant;
    logic             busy;

    conv_rr_arbiter #(.N(N), .X(X), .F(F), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_x_data  (req_x_data),
        .req_x_valid (req_x_valid),
        .req_x_ready (req_x_ready),
        .req_y_data  (req_y_data),
        .req_y_valid (req_y_valid),
        .req_y_ready (req_y_ready),
        .eng_x_data  (eng_x_data),
        .eng_x_valid (eng_x_valid),
        .eng_x_ready (eng_x_ready),
        .eng_y_data  (eng_y_data),
        .eng_y_valid (eng_y_valid),
        .eng_y_ready (eng_y_ready),
        .grant       (grant),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;

    int           testsRun = 0;
    int           testsFailed = 0;
    exp_t         expQ[$];
    logic [W-1:0] txQ0[$];
    logic [W-1:0] txQ1[$];
    logic [W-1:0] sentBuf0[X];
    logic [W-1:0] sentBuf1[X];
    int           sentCnt[N];
    int           stallLeft[N];
    bit           stallArm[N];
    bit           toggleY1;
    int           cycleNum;
    logic [W-1:0] engBuf[X];
    logic [W-1:0] engOut[YN];
    int           engCnt;
    int           engOutIdx;
    bit           engDrain;
    int           jobOut[N];
    int           totalOut[N];
    logic [N-1:0] grantLog[$];
    int           gapLog[$];
    int           lastEndCycle;
    logic [N-1:0] prevGrant;
    int           viol;

    // Engine filter ROM contents.
    function automatic int tap(input int j);
        case (j)
            0: return 3;
            1: return -1;
            2: return 2;
            3: return -2;
            4: return 1;
            default: return 1;
        endcase
    endfunction

    function automatic logic [W-1:0] reluDot(input logic [W-1:0] b[X], input int k);
        int acc;
        acc = 0;
        for (int j = 0; j < F; j++) begin
            acc += tap(j) * int'($signed(b[k+j]));
        end
        if (acc < 0) return '0;
        return acc[W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic resetModels();
        expQ.delete();
        txQ0.delete();
        txQ1.delete();
        for (int i = 0; i < N; i++) begin
            sentCnt[i]   = 0;
            stallLeft[i] = 0;
            stallArm[i]  = 0;
            jobOut[i]    = 0;
        end
        engCnt    = 0;
        engOutIdx = 0;
        engDrain  = 0;
        prevGrant = '0;
    endtask

    task automatic enqueueJob(input int id, input int mode);
        logic [W-1:0] s;
        for (int k = 0; k < X; k++) begin
            if (mode == 0) s = W'(k + 1);
            else           s = W'($urandom_range(0, 200)) - 16'd100;
            if (id == 0) txQ0.push_back(s);
            else         txQ1.push_back(s);
        end
    endtask

    // Record everything that happens on the coming rising edge.
    task automatic observe();
        exp_t         e;
        logic [W-1:0] s;
        cycleNum++;
        if (((req_x_ready & ~grant) != 0) || ((req_y_valid & ~grant) != 0) ||
            ((grant != 0) != busy) ||
            (eng_y_ready && ((req_y_ready & grant) == 0)) ||
            (eng_x_valid && ((req_x_valid & grant) == 0)))
            viol++;
        if (grant != 0 && prevGrant == 0) begin
            grantLog.push_back(grant);
            gapLog.push_back(cycleNum - lastEndCycle);
        end
        prevGrant = grant;
        for (int i = 0; i < N; i++) begin
            if (req_y_valid[i] && req_y_ready[i]) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_requester", i, e.id);
                    checkOutput("out_data", req_y_data, e.data);
                end
                jobOut[i]++;
                totalOut[i]++;
                if (jobOut[i] == YN) begin
                    jobOut[i]    = 0;
                    lastEndCycle = cycleNum;
                end
            end
        end
        if (eng_x_valid && eng_x_ready && engCnt < X) begin
            engBuf[engCnt] = eng_x_data;
            engCnt++;
            if (engCnt == X) begin
                for (int k = 0; k < YN; k++) engOut[k] = reluDot(engBuf, k);
                engDrain  = 1;
                engOutIdx = 0;
            end
        end
        if (eng_y_valid && eng_y_ready) begin
            engOutIdx++;
            if (engOutIdx == YN) begin
                engDrain = 0;
                engCnt   = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_x_valid[i] && req_x_ready[i]) begin
                s = (i == 0) ? txQ0.pop_front() : txQ1.pop_front();
                if (i == 0) sentBuf0[sentCnt[i]] = s;
                else        sentBuf1[sentCnt[i]] = s;
                sentCnt[i]++;
                if (stallArm[i] && sentCnt[i] == 10) begin
                    stallLeft[i] = 5;
                    stallArm[i]  = 0;
                end
                if (sentCnt[i] == X) begin
                    for (int k = 0; k < YN; k++) begin
                        e.id   = i;
                        e.data = (i == 0) ? reluDot(sentBuf0, k) : reluDot(sentBuf1, k);
                        expQ.push_back(e);
                    end
                    sentCnt[i] = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus();
        logic v0, v1;
        int   p;
        v0 = (stallLeft[0] == 0) && (txQ0.size() > 0);
        v1 = (stallLeft[1] == 0) && (txQ1.size() > 0);
        for (int i = 0; i < N; i++) if (stallLeft[i] > 0) stallLeft[i]--;
        req_x_valid = {v1, v0};
        req_x_data  = {(txQ1.size() > 0) ? txQ1[0] : 16'h0, (txQ0.size() > 0) ? txQ0[0] : 16'h0};
        p = cycleNum % 4;
        req_y_ready[0] = 1'b1;
        req_y_ready[1] = toggleY1 ? (p == 0 || p == 3) : 1'b1;
        eng_x_ready = !engDrain;
        eng_y_valid = engDrain;
        eng_y_data  = engDrain ? engOut[engOutIdx] : '0;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        while (!(txQ0.size() == 0 && txQ1.size() == 0 && expQ.size() == 0 &&
                 !engDrain && engCnt == 0 && grant == 0) && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("jobs_done_in_budget", (n < budget), 32'd1);
    endtask

    task automatic checkQuietOutputs(input string tag);
        checkOutput({tag, "_grant"},       grant,       '0);
        checkOutput({tag, "_busy"},        busy,        '0);
        checkOutput({tag, "_req_x_ready"}, req_x_ready, '0);
        checkOutput({tag, "_req_y_valid"}, req_y_valid, '0);
        checkOutput({tag, "_eng_x_valid"}, eng_x_valid, '0);
        checkOutput({tag, "_eng_y_ready"}, eng_y_ready, '0);
    endtask

    initial begin
        int base0, base1, n;
        reset        = 1'b0;
        req_x_data   = '0;
        req_x_valid  = '0;
        req_y_ready  = '0;
        eng_x_ready  = 1'b0;
        eng_y_valid  = 1'b0;
        eng_y_data   = '0;
        toggleY1     = 0;
        cycleNum     = 0;
        viol         = 0;
        lastEndCycle = -100;
        for (int i = 0; i < N; i++) totalOut[i] = 0;
        resetModels();
        #13;
        checkQuietOutputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus();

        // Single requester: one arbitration cycle, then a full job.
        $display("[TB] single requester job");
        enqueueJob(0, 0);
        applyStimulus();
        @(negedge clk);
        checkOutput("arb_cycle_grant", grant, 2'b00);
        checkOutput("arb_cycle_ready", req_x_ready, 2'b00);
        observe();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        checkOutput("first_grant", grant, 2'b01);
        observe();
        @(posedge clk);
        #1;
        applyStimulus();
        runUntilIdle(2000);
        checkOutput("single_out_count", totalOut[0], YN);
        checkOutput("single_busy_after", busy, 1'b0);

        // Pointer now at 1: simultaneous requests with backpressure on r1 and a load stall on r0.
        $display("[TB] pointer order, backpressure and load stall");
        grantLog.delete();
        gapLog.delete();
        base0 = totalOut[0];
        base1 = totalOut[1];
        enqueueJob(0, 1);
        enqueueJob(1, 1);
        enqueueJob(1, 1);
        stallArm[0] = 1;
        toggleY1    = 1;
        applyStimulus();
        runUntilIdle(4000);
        toggleY1 = 0;
        checkOutput("t2_grants", grantLog.size(), 3);
        if (grantLog.size() == 3) begin
            checkOutput("t2_grant0", grantLog[0], 2'b10);
            checkOutput("t2_grant1", grantLog[1], 2'b01);
            checkOutput("t2_grant2", grantLog[2], 2'b10);
            checkOutput("t2_gap1", gapLog[1], 2);
            checkOutput("t2_gap2", gapLog[2], 2);
        end
        checkOutput("t2_r0_count", totalOut[0] - base0, YN);
        checkOutput("t2_r1_count", totalOut[1] - base1, 2 * YN);

        // Fairness: both requesters always have work.
        $display("[TB] fairness over four jobs");
        grantLog.delete();
        gapLog.delete();
        enqueueJob(0, 1);
        enqueueJob(0, 1);
        enqueueJob(1, 1);
        enqueueJob(1, 1);
        applyStimulus();
        runUntilIdle(4000);
        checkOutput("fair_grants", grantLog.size(), 4);
        if (grantLog.size() == 4) begin
            checkOutput("fair_grant0", grantLog[0], 2'b01);
            checkOutput("fair_grant1", grantLog[1], 2'b10);
            checkOutput("fair_grant2", grantLog[2], 2'b01);
            checkOutput("fair_grant3", grantLog[3], 2'b10);
            checkOutput("fair_gap3", gapLog[3], 2);
        end

        // Reset in the middle of a drain, then a fresh job from requester 1.
        $display("[TB] reset mid-drain");
        enqueueJob(0, 1);
        applyStimulus();
        n = 0;
        while (!(jobOut[0] == 12) && n < 1000) begin
            stepCycle();
            n++;
        end
        checkOutput("reached_mid_drain", (n < 1000), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkQuietOutputs("mid_reset");
        resetModels();
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        base0 = totalOut[0];
        base1 = totalOut[1];
        grantLog.delete();
        gapLog.delete();
        enqueueJob(1, 1);
        applyStimulus();
        runUntilIdle(2000);
        checkOutput("post_reset_grant_count", grantLog.size(), 1);
        if (grantLog.size() == 1) checkOutput("post_reset_grant", grantLog[0], 2'b10);
        checkOutput("post_reset_r1_count", totalOut[1] - base1, YN);
        checkOutput("post_reset_r0_none", totalOut[0] - base0, 0);

        checkOutput("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv_rr_arbiter.md
Name: conv_rr_arbiter

Overview:
- Shares one conv engine (X-sample input stream, F-tap ROM filter, X-F+1 ReLU outputs over valid/ready) between N requester streams.
- Round-robin grant per job. A job is X input samples loaded, then X-F+1 outputs drained.
- Sits between requester front-ends and a single conv_X_F engine instance. It forwards handshakes and does not buffer data.

Parameters:
- N, 2, number of requesters (N >= 1)
- X, 32, input samples per job
- F, 6, filter taps; outputs per job = X-F+1
- W, 16, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_x_data  in  N*W  requester i input sample at bits [i*W +: W]
- req_x_valid  in  N  requester input valid
- req_x_ready  out  N  requester input ready
- req_y_data  out  W  output sample, broadcast to all requesters
- req_y_valid  out  N  output valid, granted requester only
- req_y_ready  in  N  requester output ready
- eng_x_data  out  W  to engine x_data
- eng_x_valid  out  1  to engine x_valid
- eng_x_ready  in  1  from engine x_ready
- eng_y_data  in  W  from engine y_data
- eng_y_valid  in  1  from engine y_valid
- eng_y_ready  out  1  to engine y_ready
- grant  out  N  one-hot grant; all zeros in IDLE
- busy  out  1  high in LOAD or DRAIN

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, gidx=0, x_cnt=0, y_cnt=0.
  - All outputs 0: grant, busy, req_x_ready, req_y_valid, eng_x_valid, eng_y_ready.
  - Engine must share the same reset so both restart together. Reset mid-job abandons the job; no partial outputs afterwards.
- States: IDLE, LOAD, DRAIN. All transitions are registered.
- IDLE:
  - Search req_x_valid starting at rr_ptr, ascending, wrapping mod N. The first set bit wins and sets gidx.
  - Winner present -> next state LOAD, x_cnt=0, y_cnt=0. None present -> stay.
  - No handshakes are forwarded in IDLE.
  - Arbitration latency: a request seen in cycle t is granted from t+1. No data is accepted in cycle t.
- LOAD (combinational forwarding):
  - eng_x_data = req_x_data[gidx].
  - eng_x_valid = req_x_valid[gidx].
  - req_x_ready[gidx] = eng_x_ready; all other ready bits 0.
  - eng_y_ready = 0; req_y_valid = 0.
- LOAD counting and exit:
  - x_cnt increments on each handshake (eng_x_valid & eng_x_ready).
  - On the X-th handshake -> next state DRAIN.
  - If the requester drops valid mid-load, the block stalls without timeout. The grant is held and other requesters are ignored.
- DRAIN (combinational forwarding):
  - req_y_data = eng_y_data.
  - req_y_valid[gidx] = eng_y_valid; others 0.
  - eng_y_ready = req_y_ready[gidx].
  - All req_x_ready = 0; eng_x_valid = 0.
- DRAIN counting and exit:
  - y_cnt increments on each handshake (eng_y_valid & eng_y_ready).
  - On the (X-F+1)-th handshake -> next state IDLE, rr_ptr = (gidx+1) mod N, grant cleared.
- Minimum gap between jobs is one IDLE cycle.
- Counter widths: $clog2(X+1) bits each; counters never wrap within a job.
- Boundary cases:
  - N=1: always grants requester 0.
  - Simultaneous requests: pointer order decides.
  - Requester 0 requesting continuously while requester 1 waits: requester 1 gets the next job.
  - Engine y_valid during LOAD: not forwarded, not counted.
  - eng_x_ready low in LOAD: requester stalls.
  - Last-output handshake and a new request in the same cycle: the new request is evaluated in the following IDLE cycle.
- Outputs are combinational from state and gidx, so there is no added data latency. Total job latency = engine latency + 1 arbitration cycle.

Test Plan:
- Single requester, both inputs valid every cycle, X=32, F=6, y_ready=1:
  - Requester 0 sends samples 1..32; grant=01 from cycle 1.
  - Exactly 27 req_y_valid[0] pulses, values match the engine golden model.
  - Then IDLE, busy=0, rr_ptr=1.
- Simultaneous requests, req_x_valid=11 after reset:
  - Requester 0 granted first; requester 1 granted right after requester 0's 27th output plus one IDLE cycle.
  - Requester 1 receives 27 outputs; req_y_valid[0] stays 0 during requester 1's drain.
- Backpressure: requester 1 y_ready toggles 1,0,0,1 repeating:
  - eng_y_ready mirrors it; y_cnt advances only on handshakes.
  - Still exactly 27 outputs, no duplicates or drops.
- Load stall: granted requester drops x_valid for 5 cycles after sample 10:
  - x_cnt holds at 10; the other requester's x_ready stays 0; the job completes correctly.
- Reset mid-job: reset=0 asynchronously during DRAIN at y_cnt=12:
  - All outputs 0 immediately, state IDLE, rr_ptr=0.
  - After release, a new job from requester 1 completes with 27 outputs.
- Fairness: both requesters valid continuously for 4 jobs:
  - Grant sequence 01,10,01,10.
